spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
Register-bus responder for the SPI controller: the target end of the S_AWADDR/S_WDATA/S_WSTRB/S_REG_WEN write strobe and S_ARADDR/S_REG_RDEN/S_RDATA read strobe interface.
- Holds SPMODE, SPIE, SPIM and SPCOM.
- Buffers transmit and receive bytes in two FIFOs.
- Exports configuration and FIFO ports to the SPI shift engine, plus one level interrupt.

Parameters:
- FIFO_DEPTH, 8, entries per TX/RX FIFO (power of 2, 2..256)
- FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width
- SPMODE_RST, 32'h0000_100F, SPMODE reset value (equals SPMODE_DEF)

Ports:
- S_SYSCLK  in  1  platform clock
- S_RESET  in  1  synchronous active-high reset
- S_AWADDR  in  8  write address
- S_WDATA  in  32  write data
- S_WSTRB  in  4  write byte enables
- S_REG_WEN  in  1  write strobe, one write per high cycle
- S_ARADDR  in  8  read address
- S_REG_RDEN  in  1  read strobe, one read per high cycle
- S_RDATA  out  32  registered read data
- spmode  out  32  SPMODE contents
- spcom  out  32  SPCOM contents
- spcom_wr  out  1  one-cycle pulse after SPCOM write
- tx_rd  in  1  core pops TX FIFO
- tx_data  out  8  TX FIFO head (first-word fall-through)
- tx_empty  out  1  TX FIFO empty
- rx_wr  in  1  core pushes RX FIFO
- rx_data  in  8  byte to push
- core_done  in  1  transfer-complete pulse
- irq  out  1  |(SPIE & SPIM), registered

Behaviour:
- Address map, byte addresses; unmapped addresses read 0 and ignore writes:
  - 0x00 SPMODE: RW
  - 0x04 SPIE: bits W1C/RO
  - 0x08 SPIM: RW, [5:0]
  - 0x0C SPCOM: RW
  - 0x10 SPITF: WO
  - 0x14 SPIRF: RO
- Writes:
  - Sampled on the posedge where S_REG_WEN=1.
  - For SPMODE/SPIM/SPCOM, S_WSTRB[i] gates byte i.
  - Register updates are visible on the next cycle.
- Reads:
  - On the posedge where S_REG_RDEN=1, S_RDATA is loaded from the S_ARADDR register.
  - S_RDATA holds until the next read. Latency is 1 cycle, so the value is valid one cycle after the strobe.
- SPIE bits:
  - [0] DON: sticky, set by core_done.
  - [1] RNE: live, RX not empty.
  - [2] TNF: live, TX not full.
  - [3] OV: sticky, RX push while full.
  - [4] UN: sticky, tx_rd while TX empty.
  - [5] ERR: see Optional Feature.
  - [15:8] RX count, [23:16] TX count, zero-extended.
  - Sticky bits clear on a write of 1 with WSTRB[0]. If set and clear land in the same cycle, set wins.
- SPITF write with WSTRB[0] pushes WDATA[7:0].
  - If full and no tx_rd that cycle, the byte is dropped; no flag.
  - If full and tx_rd in the same cycle, both the push and the pop happen and the count is unchanged.
- SPIRF read:
  - Returns {24'b0, head} and pops one entry.
  - If empty, returns 0 and does not pop.
- rx_wr when full:
  - Sets OV and drops the byte, unless the same cycle is a bus SPIRF pop; then the byte is accepted.
- tx_rd when empty: sets UN and leaves the pointers unchanged.
- Simultaneous WEN and RDEN to any addresses are independent. A read of a register being written returns the old value.
- spcom_wr goes high on the cycle after an SPCOM write, for 1 cycle.
- irq is registered: it goes high 1 cycle after the SPIE/SPIM change that asserts it.
- Reset: synchronous, overrides all activity, and may occur mid-operation.
  - SPMODE=SPMODE_RST; SPIE sticky bits, SPIM and SPCOM=0.
  - FIFOs are emptied (pointers and counts 0).
  - S_RDATA=0, spcom_wr=0, irq=0, tx_empty=1.
  - Live SPIE bits after reset: RNE=0, TNF=1.

Optional Feature:
Macro: SPI_REG_ADDR_ERR_EN
- Defined: any WEN or RDEN to an unmapped address, or a write to SPIRF, sets SPIE[5] ERR (sticky, W1C, maskable via SPIM[5]).
- Not defined: SPIE[5] reads 0 and SPIM[5] is read-as-zero.

Decomposition:
- The shared include reg-bit-def.v holds:
  - ADDR_SPMODE, ADDR_SPIE, ADDR_SPIM, ADDR_SPCOM, ADDR_SPITF, ADDR_SPIRF
  - SPMODE_DEF
  - SPIE_DON/RNE/TNF/OV/UN/ERR bit indices
- One sub-module, spi_reg_fifo: synchronous FWFT FIFO with push, pop, full, empty and count, instantiated twice (TX, RX).

Test Plan:
- Reset, then read SPMODE, SPIE and SPIM -> 0x0000100F; SPIE=0x00000004 (TNF only); SPIM=0; irq=0; tx_empty=1.
- Write SPCOM=0xA5A5_0003 with WSTRB=4'b0011 -> readback 0x0000_0003; spcom_wr is a single 1-cycle pulse.
- Push 8 bytes 0x11..0x18 to SPITF, then a 9th byte 0x19:
  - SPIE.TNF=0 and TX count=8; 0x19 is dropped.
  - tx_data presents 0x11 first; after 8 tx_rd pulses, one more tx_rd sets UN.
- Core pushes 0x3C via rx_wr -> RNE=1; read SPIRF -> 0x0000003C; the next SPIRF read returns 0 with RNE=0.
- Fill RX with 8 bytes, then assert rx_wr -> OV set:
  - With SPIM=0x08, irq rises 1 cycle later.
  - Writing SPIE=0x08 clears OV and irq; if OV is re-triggered in the same cycle as the W1C write, OV stays 1.
- With SPI_REG_ADDR_ERR_EN, read 0x40 -> S_RDATA=0 and ERR=1; without the macro, ERR stays 0.

Source files
------------

// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register responder: address map, SPIE bit
// positions, SPMODE default, address decode and byte-strobe merge helpers.
package spi_reg_slave_pkg;

    localparam logic [7:0]  ADDR_SPMODE = 8'h00;
    localparam logic [7:0]  ADDR_SPIE   = 8'h04;
    localparam logic [7:0]  ADDR_SPIM   = 8'h08;
    localparam logic [7:0]  ADDR_SPCOM  = 8'h0C;
    localparam logic [7:0]  ADDR_SPITF  = 8'h10;
    localparam logic [7:0]  ADDR_SPIRF  = 8'h14;

    localparam logic [31:0] SPMODE_DEF  = 32'h0000_100F;

    localparam int SPIE_DON = 0;
    localparam int SPIE_RNE = 1;
    localparam int SPIE_TNF = 2;
    localparam int SPIE_OV  = 3;
    localparam int SPIE_UN  = 4;
    localparam int SPIE_ERR = 5;

    typedef enum logic [2:0] {
        SEL_SPMODE = 3'd0,
        SEL_SPIE   = 3'd1,
        SEL_SPIM   = 3'd2,
        SEL_SPCOM  = 3'd3,
        SEL_SPITF  = 3'd4,
        SEL_SPIRF  = 3'd5,
        SEL_NONE   = 3'd6
    } reg_sel_e;

    // Exact byte-address match; anything else (including misaligned) is unmapped.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_SPMODE: sel = SEL_SPMODE;
            ADDR_SPIE:   sel = SEL_SPIE;
            ADDR_SPIM:   sel = SEL_SPIM;
            ADDR_SPCOM:  sel = SEL_SPCOM;
            ADDR_SPITF:  sel = SEL_SPITF;
            ADDR_SPIRF:  sel = SEL_SPIRF;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// Register-bus strobe interface between the bus master and the SPI register block.
interface spi_reg_slave_if;
    logic [7:0]  S_AWADDR;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_REG_WEN;
    logic [7:0]  S_ARADDR;
    logic        S_REG_RDEN;
    logic [31:0] S_RDATA;

    modport master (
        output S_AWADDR, S_WDATA, S_WSTRB, S_REG_WEN, S_ARADDR, S_REG_RDEN,
        input  S_RDATA
    );

    modport slave (
        input  S_AWADDR, S_WDATA, S_WSTRB, S_REG_WEN, S_ARADDR, S_REG_RDEN,
        output S_RDATA
    );
endinterface

// File: rtl/spi_reg_fifo.sv
// Synchronous first-word-fall-through FIFO used for the SPI TX and RX byte
// queues. A push while full is accepted only when a pop commits in the same
// cycle; a pop while empty is ignored.
module spi_reg_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    // Decide which operations commit and advance pointers/count accordingly.
    always_comb begin
        do_pop_s  = pop && (cnt_q != {(AW+1){1'b0}});
        do_push_s = push && ((cnt_q != DEPTH_C) || do_pop_s);
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == {(AW+1){1'b0}});
    assign count    = cnt_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI controller register responder: SPMODE/SPIE/SPIM/SPCOM registers, TX/RX
// byte FIFOs toward the shift engine, and a registered level interrupt.
// Optional build macro SPI_REG_ADDR_ERR_EN enables the sticky SPIE[5] ERR bit
// for unmapped accesses and SPIRF writes; without it ERR and SPIM[5] read 0.
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = $clog2(FIFO_DEPTH),
    parameter logic [31:0] SPMODE_RST = SPMODE_DEF
) (
    input  logic           S_SYSCLK,
    input  logic           S_RESET,
    spi_reg_slave_if.slave bus,
    output logic [31:0]    spmode,
    output logic [31:0]    spcom,
    output logic           spcom_wr,
    input  logic           tx_rd,
    output logic [7:0]     tx_data,
    output logic           tx_empty,
    input  logic           rx_wr,
    input  logic [7:0]     rx_data,
    input  logic           core_done,
    output logic           irq
);

    logic [31:0] spmode_q, spmode_d, spcom_q, spcom_d, rdata_q, rdata_d;
    logic [5:0]  spim_q, spim_d;
    logic        don_q, don_d, ov_q, ov_d, un_q, un_d, err_q, err_d;
    logic        spcom_wr_q, spcom_wr_d, irq_q, irq_d;

    reg_sel_e    wr_sel_s, rd_sel_s;
    logic        tx_push_s, rx_pop_s, err_set_s;
    logic [5:0]  spie_clr_s;
    logic [31:0] spie_s;
    logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [7:0]  rx_head_s;
    logic [FIFO_AW:0] tx_cnt_s, rx_cnt_s;
    logic [15:0] tx_cnt_w_s, rx_cnt_w_s;

    spi_reg_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(8)) u_tx_fifo (
        .clk(S_SYSCLK), .rst(S_RESET), .push(tx_push_s), .push_data(bus.S_WDATA[7:0]),
        .pop(tx_rd), .pop_data(tx_data), .full(tx_full_s), .empty(tx_empty_s),
        .count(tx_cnt_s)
    );

    spi_reg_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(8)) u_rx_fifo (
        .clk(S_SYSCLK), .rst(S_RESET), .push(rx_wr), .push_data(rx_data),
        .pop(rx_pop_s), .pop_data(rx_head_s), .full(rx_full_s), .empty(rx_empty_s),
        .count(rx_cnt_s)
    );

    // Address decode, FIFO strobes, W1C mask and SPIE status image.
    always_comb begin
        wr_sel_s   = decode_addr(bus.S_AWADDR);
        rd_sel_s   = decode_addr(bus.S_ARADDR);
        tx_push_s  = bus.S_REG_WEN && (wr_sel_s == SEL_SPITF) && bus.S_WSTRB[0];
        rx_pop_s   = bus.S_REG_RDEN && (rd_sel_s == SEL_SPIRF);
        if (bus.S_REG_WEN && (wr_sel_s == SEL_SPIE) && bus.S_WSTRB[0]) begin
            spie_clr_s = bus.S_WDATA[5:0];
        end else begin
            spie_clr_s = 6'd0;
        end
`ifdef SPI_REG_ADDR_ERR_EN
        err_set_s = (bus.S_REG_WEN && ((wr_sel_s == SEL_NONE) || (wr_sel_s == SEL_SPIRF)))
                 || (bus.S_REG_RDEN && (rd_sel_s == SEL_NONE));
`else
        err_set_s = 1'b0;
`endif
        // Counts are zero-extended; only a 256-deep FIFO can exceed a byte.
        tx_cnt_w_s = 16'(tx_cnt_s);
        rx_cnt_w_s = 16'(rx_cnt_s);
        spie_s = 32'd0;
        spie_s[SPIE_DON] = don_q;
        spie_s[SPIE_RNE] = !rx_empty_s;
        spie_s[SPIE_TNF] = !tx_full_s;
        spie_s[SPIE_OV]  = ov_q;
        spie_s[SPIE_UN]  = un_q;
        spie_s[SPIE_ERR] = err_q;
        spie_s[15:8]  = (rx_cnt_w_s > 16'd255) ? 8'hFF : rx_cnt_w_s[7:0];
        spie_s[23:16] = (tx_cnt_w_s > 16'd255) ? 8'hFF : tx_cnt_w_s[7:0];
    end

    // Next-state for control registers, sticky flags, pulse and interrupt.
    always_comb begin
        spmode_d   = spmode_q;
        spcom_d    = spcom_q;
        spim_d     = spim_q;
        if (bus.S_REG_WEN && (wr_sel_s == SEL_SPMODE)) begin
            spmode_d = apply_wstrb(spmode_q, bus.S_WDATA, bus.S_WSTRB);
        end else begin
            spmode_d = spmode_q;
        end
        if (bus.S_REG_WEN && (wr_sel_s == SEL_SPCOM)) begin
            spcom_d = apply_wstrb(spcom_q, bus.S_WDATA, bus.S_WSTRB);
        end else begin
            spcom_d = spcom_q;
        end
        if (bus.S_REG_WEN && (wr_sel_s == SEL_SPIM) && bus.S_WSTRB[0]) begin
            spim_d = bus.S_WDATA[5:0];
        end else begin
            spim_d = spim_q;
        end
`ifndef SPI_REG_ADDR_ERR_EN
        spim_d[SPIE_ERR] = 1'b0;
`endif
        // Set has priority over a same-cycle W1C.
        don_d = (don_q && !spie_clr_s[SPIE_DON]) || core_done;
        ov_d  = (ov_q  && !spie_clr_s[SPIE_OV])  || (rx_wr && rx_full_s && !rx_pop_s);
        un_d  = (un_q  && !spie_clr_s[SPIE_UN])  || (tx_rd && tx_empty_s);
        err_d = (err_q && !spie_clr_s[SPIE_ERR]) || err_set_s;
        spcom_wr_d = bus.S_REG_WEN && (wr_sel_s == SEL_SPCOM);
        irq_d      = |(spie_s[5:0] & spim_q);
    end

    // Read data mux; values are pre-write, and S_RDATA holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.S_REG_RDEN) begin
            case (rd_sel_s)
                SEL_SPMODE: rdata_d = spmode_q;
                SEL_SPIE:   rdata_d = spie_s;
                SEL_SPIM:   rdata_d = {26'd0, spim_q};
                SEL_SPCOM:  rdata_d = spcom_q;
                SEL_SPIRF:  rdata_d = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers; synchronous reset overrides any bus or core activity.
    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET) begin
            spmode_q   <= SPMODE_RST;
            spcom_q    <= 32'd0;
            spim_q     <= 6'd0;
            rdata_q    <= 32'd0;
            don_q      <= 1'b0;
            ov_q       <= 1'b0;
            un_q       <= 1'b0;
            err_q      <= 1'b0;
            spcom_wr_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            spmode_q   <= spmode_d;
            spcom_q    <= spcom_d;
            spim_q     <= spim_d;
            rdata_q    <= rdata_d;
            don_q      <= don_d;
            ov_q       <= ov_d;
            un_q       <= un_d;
            err_q      <= err_d;
            spcom_wr_q <= spcom_wr_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.S_RDATA = rdata_q;
    assign spmode      = spmode_q;
    assign spcom       = spcom_q;
    assign spcom_wr    = spcom_wr_q;
    assign irq         = irq_q;
    assign tx_empty    = tx_empty_s;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed scenarios followed by random
// traffic, all compared against a queue-based register/FIFO reference model.
module tb_spi_reg_slave;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_rd, rx_wr, core_done, spcom_wr, tx_empty, irq;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] spmode, spcom;

    spi_reg_slave_if bus_if ();

    spi_reg_slave #(.FIFO_DEPTH(DEPTH)) dut (
        .S_SYSCLK(clk), .S_RESET(rst), .bus(bus_if),
        .spmode(spmode), .spcom(spcom), .spcom_wr(spcom_wr),
        .tx_rd(tx_rd), .tx_data(tx_data), .tx_empty(tx_empty),
        .rx_wr(rx_wr), .rx_data(rx_data), .core_done(core_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stimulus for the next cycle.
    bit        s_rst, s_wen, s_rden, s_txrd, s_rxwr, s_done;
    bit [7:0]  s_aw, s_ar, s_rxd;
    bit [31:0] s_wd;
    bit [3:0]  s_ws;

    // Reference model state.
    bit [7:0]  m_tx[$];
    bit [7:0]  m_rx[$];
    bit [31:0] m_spmode, m_spcom, m_rdata;
    bit [5:0]  m_spim;
    bit        m_don, m_ov, m_un, m_err, m_spcom_wr, m_irq;

    function automatic bit [31:0] m_spie();
        bit [31:0] v;
        v = 32'd0;
        v[0] = m_don;
        v[1] = (m_rx.size() != 0);
        v[2] = (m_tx.size() < DEPTH);
        v[3] = m_ov;
        v[4] = m_un;
        v[5] = m_err;
        v[15:8]  = 8'(m_rx.size());
        v[23:16] = 8'(m_tx.size());
        return v;
    endfunction

    function automatic bit is_mapped(input bit [7:0] a);
        return (a == 8'h00) || (a == 8'h04) || (a == 8'h08) || (a == 8'h0C)
            || (a == 8'h10) || (a == 8'h14);
    endfunction

    function automatic void model_reset();
        m_tx.delete();
        m_rx.delete();
        m_spmode = 32'h0000_100F;
        m_spcom = 32'd0;
        m_rdata = 32'd0;
        m_spim = 6'd0;
        {m_don, m_ov, m_un, m_err, m_spcom_wr, m_irq} = 6'd0;
    endfunction

    // Advance the model by one clock edge using the current stimulus.
    function automatic void model_step();
        bit [31:0] spie_old;
        int        rx_n, tx_n;
        bit        rx_pop, tx_pop, err_set;
        bit [5:0]  clr;
        if (s_rst) begin
            model_reset();
            return;
        end
        spie_old = m_spie();
        rx_n = m_rx.size();
        tx_n = m_tx.size();
        if (s_rden) begin
            case (s_ar)
                8'h00:   m_rdata = m_spmode;
                8'h04:   m_rdata = spie_old;
                8'h08:   m_rdata = {26'd0, m_spim};
                8'h0C:   m_rdata = m_spcom;
                8'h14:   m_rdata = (rx_n > 0) ? {24'd0, m_rx[0]} : 32'd0;
                default: m_rdata = 32'd0;
            endcase
        end
        rx_pop = s_rden && (s_ar == 8'h14) && (rx_n > 0);
        tx_pop = s_txrd && (tx_n > 0);
        m_irq = |(spie_old[5:0] & m_spim);
        clr = (s_wen && (s_aw == 8'h04) && s_ws[0]) ? s_wd[5:0] : 6'd0;
        m_don = (m_don && !clr[0]) || s_done;
        m_ov  = (m_ov && !clr[3]) || (s_rxwr && (rx_n == DEPTH) && !rx_pop);
        m_un  = (m_un && !clr[4]) || (s_txrd && (tx_n == 0));
`ifdef SPI_REG_ADDR_ERR_EN
        err_set = (s_wen && (!is_mapped(s_aw) || (s_aw == 8'h14))) || (s_rden && !is_mapped(s_ar));
`else
        err_set = 1'b0;
`endif
        m_err = (m_err && !clr[5]) || err_set;
        if (rx_pop) void'(m_rx.pop_front());
        if (s_rxwr && ((rx_n < DEPTH) || rx_pop)) m_rx.push_back(s_rxd);
        if (tx_pop) void'(m_tx.pop_front());
        if (s_wen && (s_aw == 8'h10) && s_ws[0] && ((tx_n < DEPTH) || tx_pop)) m_tx.push_back(s_wd[7:0]);
        m_spcom_wr = s_wen && (s_aw == 8'h0C);
        if (s_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (s_ws[b] && (s_aw == 8'h00)) m_spmode[8*b +: 8] = s_wd[8*b +: 8];
                if (s_ws[b] && (s_aw == 8'h0C)) m_spcom[8*b +: 8] = s_wd[8*b +: 8];
            end
            if (s_ws[0] && (s_aw == 8'h08)) m_spim = s_wd[5:0];
`ifndef SPI_REG_ADDR_ERR_EN
            m_spim[5] = 1'b0;
`endif
        end
    endfunction

    task automatic check_outputs();
        check_eq("rdata", bus_if.S_RDATA, m_rdata);
        check_eq("spmode", spmode, m_spmode);
        check_eq("spcom", spcom, m_spcom);
        check_eq("spcom_wr", 32'(spcom_wr), 32'(m_spcom_wr));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("tx_empty", 32'(tx_empty), 32'(m_tx.size() == 0));
        if (m_tx.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(m_tx[0]));
    endtask

    task automatic set_idle();
        {s_rst, s_wen, s_rden, s_txrd, s_rxwr, s_done} = 6'd0;
        s_aw = 8'd0; s_ar = 8'd0; s_rxd = 8'd0; s_wd = 32'd0; s_ws = 4'd0;
    endtask

    // Drive stimulus at the falling edge, step the model, check at the next falling edge.
    task automatic tick();
        rst = s_rst;
        bus_if.S_REG_WEN = s_wen; bus_if.S_AWADDR = s_aw;
        bus_if.S_WDATA = s_wd;    bus_if.S_WSTRB = s_ws;
        bus_if.S_REG_RDEN = s_rden; bus_if.S_ARADDR = s_ar;
        tx_rd = s_txrd; rx_wr = s_rxwr; rx_data = s_rxd; core_done = s_done;
        model_step();
        @(negedge clk);
        check_outputs();
        set_idle();
    endtask

    task automatic do_wr(input bit [7:0] a, input bit [31:0] d, input bit [3:0] st);
        s_wen = 1'b1; s_aw = a; s_wd = d; s_ws = st;
        tick();
    endtask

    task automatic do_rd(input bit [7:0] a);
        s_rden = 1'b1; s_ar = a;
        tick();
    endtask

    bit [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'h01};

    initial begin
        set_idle();
        s_rst = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b1; tick();
        s_rst = 1'b1; tick();
        check_eq("rst_rdata", bus_if.S_RDATA, 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_tx_empty", 32'(tx_empty), 32'd1);
        do_rd(8'h00); check_eq("rst_spmode", bus_if.S_RDATA, 32'h0000_100F);
        do_rd(8'h04); check_eq("rst_spie", bus_if.S_RDATA, 32'h0000_0004);
        do_rd(8'h08); check_eq("rst_spim", bus_if.S_RDATA, 32'd0);

        do_wr(8'h0C, 32'hA5A5_0003, 4'b0011);
        check_eq("spcom_wr_pulse", 32'(spcom_wr), 32'd1);
        tick();
        check_eq("spcom_wr_low", 32'(spcom_wr), 32'd0);
        do_rd(8'h0C); check_eq("spcom_rb", bus_if.S_RDATA, 32'h0000_0003);

        for (int i = 0; i < 9; i++) do_wr(8'h10, 32'(8'h11 + i), 4'b0001);
        do_rd(8'h04); check_eq("tx_full_spie", bus_if.S_RDATA, 32'h0008_0000);
        check_eq("tx_head_first", 32'(tx_data), 32'h11);
        for (int i = 0; i < 8; i++) begin
            check_eq("tx_order", 32'(tx_data), 32'(8'h11 + i));
            s_txrd = 1'b1; tick();
        end
        s_txrd = 1'b1; tick();
        do_rd(8'h04); check_eq("tx_underrun", bus_if.S_RDATA, 32'h0000_0014);
        do_wr(8'h04, 32'h0000_0010, 4'b0001);

        s_rxwr = 1'b1; s_rxd = 8'h3C; tick();
        do_rd(8'h04); check_eq("rx_rne", bus_if.S_RDATA, 32'h0000_0106);
        do_rd(8'h14); check_eq("rx_pop", bus_if.S_RDATA, 32'h0000_003C);
        do_rd(8'h14); check_eq("rx_empty_rd", bus_if.S_RDATA, 32'd0);
        do_rd(8'h04); check_eq("rx_rne_clr", bus_if.S_RDATA, 32'h0000_0004);

        do_wr(8'h08, 32'h0000_0008, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            s_rxwr = 1'b1; s_rxd = 8'(8'hA0 + i); tick();
        end
        s_rxwr = 1'b1; s_rxd = 8'hEE; tick();
        check_eq("irq_delay", 32'(irq), 32'd0);
        tick();
        check_eq("irq_ov", 32'(irq), 32'd1);
        s_rxwr = 1'b1; s_rxd = 8'hEF; s_wen = 1'b1; s_aw = 8'h04; s_wd = 32'h8; s_ws = 4'b0001;
        tick();
        do_rd(8'h04); check_eq("ov_set_wins", 32'(bus_if.S_RDATA[3]), 32'd1);
        do_wr(8'h04, 32'h0000_0008, 4'b0001);
        do_rd(8'h04);
        check_eq("ov_cleared", 32'(bus_if.S_RDATA[3]), 32'd0);
        check_eq("irq_cleared", 32'(irq), 32'd0);

        do_rd(8'h40); check_eq("unmapped_rd", bus_if.S_RDATA, 32'd0);
        do_rd(8'h04);
`ifdef SPI_REG_ADDR_ERR_EN
        check_eq("err_bit", 32'(bus_if.S_RDATA[5]), 32'd1);
`else
        check_eq("err_bit", 32'(bus_if.S_RDATA[5]), 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            s_rst  = ($urandom_range(0, 299) == 0);
            s_wen  = ($urandom_range(0, 1) == 0);
            s_aw   = ($urandom_range(0, 2) == 0) ? 8'h10 : addrs[$urandom_range(0, 7)];
            s_wd   = $urandom;
            s_ws   = 4'($urandom);
            s_rden = ($urandom_range(0, 1) == 0);
            s_ar   = ($urandom_range(0, 2) == 0) ? 8'h14 : addrs[$urandom_range(0, 7)];
            s_txrd = ($urandom_range(0, 3) == 0);
            s_rxwr = ($urandom_range(0, 2) == 0);
            s_rxd  = 8'($urandom);
            s_done = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
